// File: rtl/commit_trace_buffer.sv
// Retirement trace for the RiSC-16 pipeline: records writeback commits into a
// circular buffer, stops a programmable number of commits after a trigger, then serves readout.
module commit_trace_buffer #(
    parameter int p_DEPTH_LOG2 = 6,
    parameter int p_PC_LEN     = 16,
    parameter int p_DATA_LEN   = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_commit_valid,
    input  logic [p_PC_LEN-1:0]              i_commit_pc,
    input  logic [2:0]                       i_commit_opcode,
    input  logic [2:0]                       i_commit_tgt,
    input  logic [p_DATA_LEN-1:0]            i_commit_result,
    input  logic                             i_arm,
    input  logic [p_DEPTH_LOG2-1:0]          i_post_count,
    input  logic                             i_trig_pc_en,
    input  logic [p_PC_LEN-1:0]              i_trig_pc,
    input  logic                             i_trig_ext,
    input  logic [p_DEPTH_LOG2-1:0]          i_rd_addr,
    output logic [p_PC_LEN+6+p_DATA_LEN-1:0] o_rd_data,
    output logic                             o_rd_valid,
    output logic [1:0]                       o_state,
    output logic [p_DEPTH_LOG2:0]            o_count,
    output logic [p_DEPTH_LOG2:0]            o_trig_pos
);
    localparam int L = p_DEPTH_LOG2;
    localparam int D = 2 ** p_DEPTH_LOG2;
    localparam int W = p_PC_LEN + 6 + p_DATA_LEN;
    localparam logic [L:0] c_FULL = {1'b1, {L{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [L-1:0]   wr_ptr_q, wr_ptr_d;
    logic [L:0]     count_q, count_d;
    logic [L-1:0]   post_len_q, post_len_d;
    logic [L-1:0]   post_rem_q, post_rem_d;
    logic [L-1:0]   post_cnt_q, post_cnt_d;
    logic           trig_stored_q, trig_stored_d;
    logic [W-1:0]   rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic [W-1:0]   mem [D];
    logic           we;
    logic           trig_hit;
    logic [L-1:0]   oldest;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        post_len_d    = post_len_q;
        post_rem_d    = post_rem_q;
        post_cnt_d    = post_cnt_q;
        trig_stored_d = trig_stored_q;
        we            = 1'b0;
        trig_hit      = i_trig_ext |
                        (i_trig_pc_en & i_commit_valid & (i_commit_pc == i_trig_pc));

        // The post-count port is L bits wide, so it can never exceed D-1 and
        // the trigger entry can never be overwritten by post-trigger commits.
        if (i_arm) begin
            state_d       = S_ARMED;
            wr_ptr_d      = '0;
            count_d       = '0;
            post_len_d    = i_post_count;
            post_rem_d    = '0;
            post_cnt_d    = '0;
            trig_stored_d = 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    we = i_commit_valid;
                    if (trig_hit) begin
                        trig_stored_d = i_commit_valid;
                        post_rem_d    = post_len_q;
                        state_d       = (post_len_q == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    we = i_commit_valid;
                    if (i_commit_valid) begin
                        post_rem_d = post_rem_q - L'(1);
                        post_cnt_d = post_cnt_q + L'(1);
                        if (post_rem_q == L'(1)) state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end

        if (we) begin
            wr_ptr_d = wr_ptr_q + L'(1);
            if (count_q != c_FULL) count_d = count_q + (L+1)'(1);
        end
    end

    // Offset 0 of the readout window is the oldest surviving entry.
    always_comb begin
        oldest     = wr_ptr_q - count_q[L-1:0];
        rd_data_d  = mem[oldest + i_rd_addr];
        rd_valid_d = (state_q == S_DONE) && ({1'b0, i_rd_addr} < count_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            post_len_q    <= '0;
            post_rem_q    <= '0;
            post_cnt_q    <= '0;
            trig_stored_q <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            post_len_q    <= post_len_d;
            post_rem_q    <= post_rem_d;
            post_cnt_q    <= post_cnt_d;
            trig_stored_q <= trig_stored_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we && !i_rst) begin
            mem[wr_ptr_q] <= {i_commit_pc, i_commit_opcode, i_commit_tgt, i_commit_result};
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_state    = state_q;
    assign o_count    = count_q;
    // Without a stored trigger commit this points at the first post entry.
    assign o_trig_pos = count_q - {1'b0, post_cnt_q} - (L+1)'(trig_stored_q);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scenario bench for commit_trace_buffer: a 64-deep and an 8-deep instance share stimulus.
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cv = 1'b0;
    logic [15:0] pc = '0;
    logic [2:0]  opc = '0;
    logic [2:0]  tgt = '0;
    logic [15:0] res = '0;
    logic        arm = 1'b0;
    logic [5:0]  post = '0;
    logic        tpen = 1'b0;
    logic [15:0] tpc = '0;
    logic        text = 1'b0;
    logic [5:0]  rd_addr = '0;

    logic [37:0] rd_data64, rd_data8;
    logic        rd_valid64, rd_valid8;
    logic [1:0]  state64, state8;
    logic [6:0]  count64, tpos64;
    logic [3:0]  count8, tpos8;

    int errors = 0;
    int checks = 0;
    logic [37:0] stored[$];
    logic [37:0] exp_data_q[$];
    logic        exp_vld_q[$];

    always #5 clk = ~clk;

    commit_trace_buffer #(.p_DEPTH_LOG2(6), .p_PC_LEN(16), .p_DATA_LEN(16)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_commit_valid(cv), .i_commit_pc(pc),
        .i_commit_opcode(opc), .i_commit_tgt(tgt), .i_commit_result(res),
        .i_arm(arm), .i_post_count(post), .i_trig_pc_en(tpen), .i_trig_pc(tpc),
        .i_trig_ext(text), .i_rd_addr(rd_addr), .o_rd_data(rd_data64),
        .o_rd_valid(rd_valid64), .o_state(state64), .o_count(count64), .o_trig_pos(tpos64)
    );

    commit_trace_buffer #(.p_DEPTH_LOG2(3), .p_PC_LEN(16), .p_DATA_LEN(16)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_commit_valid(cv), .i_commit_pc(pc),
        .i_commit_opcode(opc), .i_commit_tgt(tgt), .i_commit_result(res),
        .i_arm(arm), .i_post_count(post[2:0]), .i_trig_pc_en(tpen), .i_trig_pc(tpc),
        .i_trig_ext(text), .i_rd_addr(rd_addr[2:0]), .o_rd_data(rd_data8),
        .o_rd_valid(rd_valid8), .o_state(state8), .o_count(count8), .o_trig_pos(tpos8)
    );

    function automatic logic [37:0] ent(input logic [15:0] p);
        logic [15:0] r;
        r = p * 16'd3 + 16'h1234;
        return {p, p[2:0], p[5:3], r};
    endfunction

    task automatic drive(input logic v, input logic [15:0] p);
        cv  = v;
        pc  = p;
        opc = p[2:0];
        tgt = p[5:3];
        res = p * 16'd3 + 16'h1234;
        @(negedge clk);
        cv = 1'b0;
    endtask

    task automatic do_arm(input logic [5:0] n);
        post = n;
        arm  = 1'b1;
        @(negedge clk);
        arm  = 1'b0;
    endtask

    task automatic test_readout64(input int n_addr, input int n_valid);
        logic [37:0] ed;
        logic        ev;
        for (int a = 0; a < n_addr; a++) begin
            rd_addr = 6'(a);
            exp_data_q.push_back(a < n_valid ? stored[a] : 38'd0);
            exp_vld_q.push_back(a < n_valid);
            @(negedge clk);
            ed = exp_data_q.pop_front();
            ev = exp_vld_q.pop_front();
            checks++;
            if (rd_valid64 !== ev) begin
                errors++;
                $display("FAIL rd_valid64 addr=%0d got=%b exp=%b", a, rd_valid64, ev);
            end
            if (ev) begin
                checks++;
                if (rd_data64 !== ed) begin
                    errors++;
                    $display("FAIL rd_data64 addr=%0d got=%h exp=%h", a, rd_data64, ed);
                end
            end
        end
    endtask

    task automatic test_readout8(input int n_addr, input int n_valid);
        logic [37:0] ed;
        logic        ev;
        for (int a = 0; a < n_addr; a++) begin
            rd_addr = 6'(a);
            exp_data_q.push_back(a < n_valid ? stored[a] : 38'd0);
            exp_vld_q.push_back(a < n_valid);
            @(negedge clk);
            ed = exp_data_q.pop_front();
            ev = exp_vld_q.pop_front();
            checks++;
            if (rd_valid8 !== ev) begin
                errors++;
                $display("FAIL rd_valid8 addr=%0d got=%b exp=%b", a, rd_valid8, ev);
            end
            if (ev) begin
                checks++;
                if (rd_data8 !== ed) begin
                    errors++;
                    $display("FAIL rd_data8 addr=%0d got=%h exp=%h", a, rd_data8, ed);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state64 !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state64); end
        checks++; if (count64 !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count64); end
        checks++; if (tpos64 !== 7'd0) begin errors++; $display("FAIL reset_tpos got=%0d exp=0", tpos64); end
        checks++; if (rd_valid64 !== 1'b0) begin errors++; $display("FAIL reset_rdv got=%b exp=0", rd_valid64); end
        checks++; if (rd_data64 !== 38'd0) begin errors++; $display("FAIL reset_rdd got=%h exp=0", rd_data64); end
        checks++; if (state8 !== 2'd0) begin errors++; $display("FAIL reset_state8 got=%0d exp=0", state8); end
        rst = 1'b0;
        tpen = 1'b1;
        tpc  = 16'h0014;
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(i + 16'h10));
        text = 1'b1;
        drive(1'b1, 16'h0014);
        text = 1'b0;
        rd_addr = '0;
        @(negedge clk);
        checks++; if (state64 !== 2'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", state64); end
        checks++; if (count64 !== 7'd0) begin errors++; $display("FAIL idle_count got=%0d exp=0", count64); end
        checks++; if (rd_valid64 !== 1'b0) begin errors++; $display("FAIL idle_rdv got=%b exp=0", rd_valid64); end
    endtask

    task automatic test_pc_trigger();
        tpen = 1'b1;
        tpc  = 16'h0014;
        do_arm(6'd3);
        checks++; if (state64 !== 2'd1) begin errors++; $display("FAIL arm_state got=%0d exp=1", state64); end
        checks++; if (count64 !== 7'd0) begin errors++; $display("FAIL arm_count got=%0d exp=0", count64); end
        stored.delete();
        for (int p = 16'h10; p <= 16'h1F; p++) begin
            drive(1'b1, 16'(p));
            if (p <= 16'h17) stored.push_back(ent(16'(p)));
            if (p == 16'h14) begin
                checks++; if (state64 !== 2'd2) begin errors++; $display("FAIL pc_post_state got=%0d exp=2", state64); end
            end
            if (p == 16'h17) begin
                checks++; if (state64 !== 2'd3) begin errors++; $display("FAIL pc_done_state got=%0d exp=3", state64); end
            end
        end
        checks++; if (count64 !== 7'd8) begin errors++; $display("FAIL pc_count got=%0d exp=8", count64); end
        checks++; if (tpos64 !== 7'd4) begin errors++; $display("FAIL pc_tpos got=%0d exp=4", tpos64); end
        test_readout64(9, 8);
    endtask

    task automatic test_wrap();
        tpen = 1'b1;
        tpc  = 16'd15;
        do_arm(6'd2);
        stored.delete();
        for (int p = 0; p < 20; p++) begin
            drive(1'b1, 16'(p));
            if (p >= 10 && p <= 17) stored.push_back(ent(16'(p)));
            if (p == 16) begin
                checks++; if (state8 !== 2'd2) begin errors++; $display("FAIL wrap_post_state got=%0d exp=2", state8); end
            end
            if (p == 17) begin
                checks++; if (state8 !== 2'd3) begin errors++; $display("FAIL wrap_done_state got=%0d exp=3", state8); end
            end
        end
        checks++; if (count8 !== 4'd8) begin errors++; $display("FAIL wrap_count got=%0d exp=8", count8); end
        checks++; if (tpos8 !== 4'd5) begin errors++; $display("FAIL wrap_tpos got=%0d exp=5", tpos8); end
        test_readout8(8, 8);
    endtask

    task automatic test_ext_trigger();
        tpen = 1'b0;
        do_arm(6'd0);
        stored.delete();
        for (int p = 16'h40; p <= 16'h42; p++) begin
            drive(1'b1, 16'(p));
            stored.push_back(ent(16'(p)));
        end
        text = 1'b1;
        drive(1'b0, 16'h0043);
        text = 1'b0;
        checks++; if (state64 !== 2'd3) begin errors++; $display("FAIL ext0_state got=%0d exp=3", state64); end
        checks++; if (count64 !== 7'd3) begin errors++; $display("FAIL ext0_count got=%0d exp=3", count64); end
        checks++; if (tpos64 !== 7'd3) begin errors++; $display("FAIL ext0_tpos got=%0d exp=3", tpos64); end
        test_readout64(4, 3);

        do_arm(6'd1);
        stored.delete();
        for (int p = 16'h50; p <= 16'h52; p++) begin
            drive(1'b1, 16'(p));
            stored.push_back(ent(16'(p)));
        end
        text = 1'b1;
        drive(1'b1, 16'h0053);
        text = 1'b0;
        stored.push_back(ent(16'h0053));
        checks++; if (state64 !== 2'd2) begin errors++; $display("FAIL ext1_post_state got=%0d exp=2", state64); end
        drive(1'b1, 16'h0054);
        stored.push_back(ent(16'h0054));
        checks++; if (state64 !== 2'd3) begin errors++; $display("FAIL ext1_state got=%0d exp=3", state64); end
        checks++; if (count64 !== 7'd5) begin errors++; $display("FAIL ext1_count got=%0d exp=5", count64); end
        checks++; if (tpos64 !== 7'd3) begin errors++; $display("FAIL ext1_tpos got=%0d exp=3", tpos64); end
        test_readout64(6, 5);
    endtask

    task automatic test_arm_vs_trigger();
        tpen = 1'b1;
        tpc  = 16'h0030;
        do_arm(6'd1);
        drive(1'b1, 16'h002E);
        drive(1'b1, 16'h002F);
        arm = 1'b1;
        drive(1'b1, 16'h0030);
        arm = 1'b0;
        checks++; if (state64 !== 2'd1) begin errors++; $display("FAIL armwin_state got=%0d exp=1", state64); end
        checks++; if (count64 !== 7'd0) begin errors++; $display("FAIL armwin_count got=%0d exp=0", count64); end
        stored.delete();
        drive(1'b1, 16'h0031); stored.push_back(ent(16'h0031));
        drive(1'b1, 16'h0030); stored.push_back(ent(16'h0030));
        checks++; if (state64 !== 2'd2) begin errors++; $display("FAIL armwin_post got=%0d exp=2", state64); end
        drive(1'b1, 16'h0032); stored.push_back(ent(16'h0032));
        checks++; if (state64 !== 2'd3) begin errors++; $display("FAIL armwin_done got=%0d exp=3", state64); end
        checks++; if (count64 !== 7'd3) begin errors++; $display("FAIL armwin_cnt got=%0d exp=3", count64); end
        checks++; if (tpos64 !== 7'd1) begin errors++; $display("FAIL armwin_tpos got=%0d exp=1", tpos64); end
        test_readout64(4, 3);
    endtask

    task automatic test_post_max();
        tpen = 1'b1;
        tpc  = 16'h0100;
        do_arm(6'd63);
        stored.delete();
        for (int p = 16'hF0; p <= 16'hFF; p++) drive(1'b1, 16'(p));
        for (int p = 16'h100; p <= 16'h13F; p++) begin
            drive(1'b1, 16'(p));
            stored.push_back(ent(16'(p)));
            if (p == 16'h13E) begin
                checks++; if (state64 !== 2'd2) begin errors++; $display("FAIL max_post_state got=%0d exp=2", state64); end
            end
        end
        checks++; if (state64 !== 2'd3) begin errors++; $display("FAIL max_done_state got=%0d exp=3", state64); end
        drive(1'b1, 16'h0140);
        checks++; if (count64 !== 7'd64) begin errors++; $display("FAIL max_count got=%0d exp=64", count64); end
        checks++; if (tpos64 !== 7'd0) begin errors++; $display("FAIL max_tpos got=%0d exp=0", tpos64); end
        test_readout64(64, 64);
    endtask

    task automatic test_reset_mid_post();
        tpen = 1'b1;
        tpc  = 16'h0200;
        do_arm(6'd4);
        drive(1'b1, 16'h0200);
        drive(1'b1, 16'h0201);
        drive(1'b1, 16'h0202);
        checks++; if (state64 !== 2'd2) begin errors++; $display("FAIL midpost_state got=%0d exp=2", state64); end
        rst = 1'b1;
        drive(1'b1, 16'h0203);
        rst = 1'b0;
        checks++; if (state64 !== 2'd0) begin errors++; $display("FAIL rstpost_state got=%0d exp=0", state64); end
        checks++; if (count64 !== 7'd0) begin errors++; $display("FAIL rstpost_count got=%0d exp=0", count64); end
        checks++; if (tpos64 !== 7'd0) begin errors++; $display("FAIL rstpost_tpos got=%0d exp=0", tpos64); end
        checks++; if (rd_valid64 !== 1'b0) begin errors++; $display("FAIL rstpost_rdv got=%b exp=0", rd_valid64); end
        for (int p = 16'h204; p <= 16'h207; p++) drive(1'b1, 16'(p));
        checks++; if (count64 !== 7'd0) begin errors++; $display("FAIL rstpost_after_cnt got=%0d exp=0", count64); end
        checks++; if (state64 !== 2'd0) begin errors++; $display("FAIL rstpost_after_st got=%0d exp=0", state64); end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_pc_trigger();
        test_wrap();
        test_ext_trigger();
        test_arm_vs_trigger();
        test_post_max();
        test_reset_mid_post();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
